// File: rtl/arf_pkg.sv
// Shared constants for the arf sink-side buffering blocks.
package arf_pkg;

   localparam int DATA_WIDTH_DEFAULT = 32;
   localparam int SINK_DEPTH_DEFAULT = 8;
   localparam int COUNT_WIDTH        = 32;

endpackage : arf_pkg

// File: rtl/sink_fifo_ram.sv
// Storage array for the arf sink FIFO: one synchronous write port and one
// asynchronous read port. Contents are deliberately left unreset.
module sink_fifo_ram
#(
   parameter int data_width = 32,
   parameter int depth      = 8,
   parameter int addr_width = 3
)(
   input  logic                  clk,
   input  logic                  we,
   input  logic [addr_width-1:0] waddr,
   input  logic [data_width-1:0] wdata,
   input  logic [addr_width-1:0] raddr,
   output logic [data_width-1:0] rdata
);

   logic [data_width-1:0] mem_q [depth];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule : sink_fifo_ram

// File: rtl/arf_sink_fifo.sv
// Req/ack sink for an arf out port, buffering captured words in a circular
// FIFO and re-presenting them on a first-word-fall-through valid/ready stream.
module arf_sink_fifo
   import arf_pkg::*;
#(
   parameter int data_width = DATA_WIDTH_DEFAULT,
   parameter int depth      = SINK_DEPTH_DEFAULT,
   parameter int addr_width = 3
)(
   input  logic                   clk,
   input  logic                   rst,
   output logic                   req,
   input  logic                   ack,
   input  logic [data_width-1:0]  din,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [data_width-1:0]  m_data,
   output logic [addr_width:0]    level,
   output logic [COUNT_WIDTH-1:0] count,
   output logic                   overflow
);

   localparam logic [addr_width:0] LVL_FULL    = (addr_width+1)'(depth);
   localparam logic [addr_width:0] LVL_REQ_MAX = (addr_width+1)'(depth - 2);

   logic [addr_width-1:0]  wptr_q, wptr_d;
   logic [addr_width-1:0]  rptr_q, rptr_d;
   logic [addr_width:0]    level_q, level_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;
   logic                   req_q, req_d;
   logic                   overflow_q, overflow_d;
   logic                   push, pop;

   always_comb begin
      pop        = (level_q != '0) & m_ready;
      // a full FIFO still accepts when the head leaves in the same cycle
      push       = ack & ((level_q < LVL_FULL) | pop);
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      count_d    = count_q;
      level_d    = level_q;
      overflow_d = overflow_q | (ack & ~push);

      if (push) begin
         wptr_d  = wptr_q + 1'b1;
         count_d = count_q + 1'b1;
      end
      if (pop) begin
         rptr_d = rptr_q + 1'b1;
      end

      case ({push, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase

      // one spare slot absorbs the ack that can follow req dropping
      req_d = (level_d <= LVL_REQ_MAX);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         level_q    <= '0;
         count_q    <= '0;
         req_q      <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         level_q    <= level_d;
         count_q    <= count_d;
         req_q      <= req_d;
         overflow_q <= overflow_d;
      end
   end

   sink_fifo_ram #(
      .data_width (data_width),
      .depth      (depth),
      .addr_width (addr_width)
   ) u_ram (
      .clk   (clk),
      .we    (push),
      .waddr (wptr_q),
      .wdata (din),
      .raddr (rptr_q),
      .rdata (m_data)
   );

   assign req      = req_q;
   assign m_valid  = (level_q != '0);
   assign level    = level_q;
   assign count    = count_q;
   assign overflow = overflow_q;

endmodule : arf_sink_fifo

// File: doc/arf_sink_fifo.md
Name: arf_sink_fifo

Overview:
- Buffering stage directly downstream of an arf `out` port.
- Acts as the req/ack sink: holds `req` high while it has room, and captures `din` on each one-cycle `ack` pulse.
- Stores captured words in a circular FIFO and re-presents them on a valid/ready stream for result collectors and checkers.
- Counts accepted words and flags any word lost to overflow.

Parameters:
- data_width, 32, width of `din` and `m_data`.
- depth, 8, FIFO entries; must be a power of two and ≥4.
- addr_width, 3, log2(depth); supplied by the instantiator and must match depth.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- req  output  1  registered request to the upstream arf out port.
- ack  input  1  one-cycle pulse from upstream; `din` is valid in that cycle.
- din  input  data_width  upstream data, sampled only when `ack`=1.
- m_valid  output  1  FIFO head is valid (level≠0).
- m_ready  input  1  downstream accepts the head this cycle.
- m_data  output  data_width  FIFO head word (first-word fall-through).
- level  output  addr_width+1  current occupancy, 0..depth.
- count  output  32  total accepted pushes; wraps modulo 2^32.
- overflow  output  1  sticky; set when an ack arrives with no room.

Behaviour:
- Reset (rst=0, asynchronous):
  - Outputs: req=0, m_valid=0, level=0, count=0, overflow=0.
  - Internal: write/read pointers=0.
  - Memory contents are not reset. `m_data` is don't-care while m_valid=0.
- Reset asserted mid-operation discards all contents and any in-flight ack.
- First rising edge after rst rises: req←1 (FIFO empty).
- pop = m_valid & m_ready.
- push = ack & (level<depth | pop).
  - Full FIFO with a simultaneous pop accepts the push.
- ack & ~push: word is dropped, overflow←1, overflow holds until reset.
- ack is honoured even when req=0 (upstream may pulse one cycle after req falls); only space decides acceptance.
- Push: mem[wptr]←din, wptr←wptr+1 (mod depth), count←count+1.
- Pop: rptr←rptr+1 (mod depth).
- Pointer wrap is natural modulo depth; no special case.
- level_next = level + push − pop. Simultaneous push and pop leaves level unchanged.
- req is registered: req←(level_next ≤ depth−2).
  - Keeps ≥1 spare slot, so the one-cycle req-to-ack lag never overflows under a compliant upstream.
- Latency: ack at edge N → word visible on m_data with m_valid=1 after edge N (cycle N+1) when the FIFO was empty.
- m_data = mem[rptr], combinational from the storage register. m_valid = (level≠0).
- Ordering is strict FIFO; no reordering or duplication.
- m_ready while m_valid=0 has no effect.
- X on `din` when ack=0 must never propagate into storage.

Decomposition:
- Shared package arf_pkg:
  - DATA_WIDTH_DEFAULT=32
  - SINK_DEPTH_DEFAULT=8
  - COUNT_WIDTH=32
- Sub-module sink_fifo_ram: depth×data_width storage.
  - One write port (we, waddr, wdata).
  - One asynchronous read port (raddr→rdata).
  - No reset.
- arf_sink_fifo holds pointers, level, req, count and overflow logic.

Test Plan:
- Reset release, m_ready=0, ack pulses every 2 cycles with din=100,101,…:
  - level climbs to 7, req drops when level_next reaches 7, no overflow.
  - m_data=100 once m_valid rises.
- Full drain: after the above, m_ready=1 continuously → m_data sequence 100..106 in order, level→0, req reasserts the cycle after level_next≤6.
- Concurrent: m_ready=1, ack every cycle with din=0..999 → level stays ≤1, count=1000, output matches input exactly, overflow=0.
- Forced overflow: hold m_ready=0, drive ack on 9 consecutive cycles ignoring req (din=1..9) → words 1..8 stored, 9 dropped, overflow=1 and stays 1 through later pops.
- Full plus simultaneous pop and ack: level=8, m_ready=1, ack with din=55 → push accepted, level stays 8, overflow stays 0, 55 emerges last.
- Async reset mid-stream: assert rst=0 between edges with level=5 → req, m_valid, level, count, overflow go to 0 before the next edge; after release the first pushed word is the first popped.
